// File: rtl/svnet_tree_accum.sv
// Signed adder tree over COUNT lanes feeding a packet accumulator; one result per last-tagged packet.
// Latency T+1 cycles from last beat accepted to result valid; a pending unaccepted result stalls every stage.
module svnet_tree_accum #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 9,
  parameter int REG_EVERY = 1,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_data_valid,
  output logic                     i_data_ready,
  input  logic                     i_data_last,
  input  logic [COUNT*WIDTH-1:0]   i_data,
  output logic                     o_data_valid,
  input  logic                     o_data_ready,
  output logic [ACC_WIDTH-1:0]     o_data,
  output logic                     o_data_overflow
);

  localparam int D   = $clog2(COUNT);
  localparam int T   = (D + REG_EVERY - 1) / REG_EVERY;
  localparam int NS  = (T > 0) ? T : 1;
  localparam int SW  = WIDTH + D;
  localparam int NL  = COUNT + 1;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < $clog2(COUNT) + WIDTH) begin : g_bad_acc_width
    $error("ACC_WIDTH is narrower than one beat sum");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  logic                    en_c;
  logic signed [SW-1:0]    lane_c   [NL];
  logic signed [SW-1:0]    tree_cur [NL];
  logic signed [SW-1:0]    tree_nxt [NL];
  logic signed [SW-1:0]    stg_q    [NS][NL];
  logic signed [SW-1:0]    stg_d    [NS][NL];
  logic                    stg_vld_q [NS];
  logic                    stg_vld_d [NS];
  logic                    stg_lst_q [NS];
  logic                    stg_lst_d [NS];

  logic signed [SW-1:0]        sum_c;
  logic                        sum_vld_c, sum_lst_c;
  logic signed [ACC_WIDTH-1:0] base_c, res_c;
  logic signed [AW1-1:0]       wide_c;
  logic                        base_ovf_c, step_ovf_c;

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, o_data_q, o_data_d;
  logic                        acc_ovf_q, acc_ovf_d, o_ovf_q, o_ovf_d, o_vld_q, o_vld_d;

  assign en_c            = !o_vld_q || o_data_ready;
  assign i_data_ready    = en_c;
  assign o_data_valid    = o_vld_q;
  assign o_data          = o_data_q;
  assign o_data_overflow = o_ovf_q;

  // Slot COUNT stays zero so an odd node always pairs with a zero partner.
  always_comb begin
    for (int j = 0; j < NL; j++) lane_c[j] = '0;
    for (int j = 0; j < COUNT; j++) lane_c[j] = SW'($signed(i_data[j*WIDTH +: WIDTH]));
  end

  always_comb begin
    tree_cur = lane_c;
    tree_nxt = lane_c;
    stg_d    = stg_q;
    for (int k = 0; k < NS; k++) begin
      if (k > 0) tree_cur = stg_q[(k > 0) ? k - 1 : 0];
      for (int r = 0; r < REG_EVERY; r++) begin
        if (k * REG_EVERY + r < D) begin
          for (int j = 0; j < NL; j++) tree_nxt[j] = '0;
          for (int j = 0; j < (COUNT + 1) / 2; j++) tree_nxt[j] = tree_cur[2*j] + tree_cur[2*j+1];
          tree_cur = tree_nxt;
        end
      end
      if (en_c) stg_d[k] = tree_cur;
    end
  end

  always_comb begin
    stg_vld_d = stg_vld_q;
    stg_lst_d = stg_lst_q;
    if (en_c) begin
      stg_vld_d[0] = i_data_valid;
      stg_lst_d[0] = i_data_valid && i_data_last;
      for (int k = 1; k < NS; k++) begin
        stg_vld_d[k] = stg_vld_q[k-1];
        stg_lst_d[k] = stg_lst_q[k-1];
      end
    end
  end

  always_comb begin
    if (T == 0) begin
      sum_c     = lane_c[0];
      sum_vld_c = i_data_valid;
      sum_lst_c = i_data_last;
    end else begin
      sum_c     = stg_q[NS-1][0];
      sum_vld_c = stg_vld_q[NS-1];
      sum_lst_c = stg_lst_q[NS-1];
    end
  end

  // One extra bit exposes any step outside the ACC_WIDTH signed range.
  always_comb begin
    base_c     = (state_q == ACCUM) ? acc_q : '0;
    base_ovf_c = (state_q == ACCUM) && acc_ovf_q;
    wide_c     = AW1'(base_c) + AW1'(sum_c);
    step_ovf_c = wide_c[ACC_WIDTH] ^ wide_c[ACC_WIDTH-1];
    res_c      = wide_c[ACC_WIDTH-1:0];
    if (SATURATE != 0 && step_ovf_c) res_c = wide_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    o_data_d  = o_data_q;
    o_ovf_d   = o_ovf_q;
    o_vld_d   = o_vld_q && !o_data_ready;
    if (en_c && sum_vld_c) begin
      if (sum_lst_c) begin
        o_data_d  = res_c;
        o_ovf_d   = base_ovf_c || step_ovf_c;
        o_vld_d   = 1'b1;
        acc_d     = '0;
        acc_ovf_d = 1'b0;
        state_d   = IDLE;
      end else begin
        acc_d     = res_c;
        acc_ovf_d = base_ovf_c || step_ovf_c;
        state_d   = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q     <= '{default: '0};
      stg_vld_q <= '{default: 1'b0};
      stg_lst_q <= '{default: 1'b0};
      state_q   <= IDLE;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      o_data_q  <= '0;
      o_ovf_q   <= 1'b0;
      o_vld_q   <= 1'b0;
    end else begin
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      stg_lst_q <= stg_lst_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      o_data_q  <= o_data_d;
      o_ovf_q   <= o_ovf_d;
      o_vld_q   <= o_vld_d;
    end
  end

endmodule

// File: tb/tb_svnet_tree_accum.sv
// Bench for svnet_tree_accum: three instances (16-bit wrap, 12-bit saturate, 12-bit wrap) share stimulus
// and are checked every cycle against a packet-sum model, plus literal expectations for directed packets.
module tb_svnet_tree_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_data_valid = 1'b0;
  logic        i_data_last = 1'b0;
  logic [71:0] i_data = '0;
  logic        o_data_ready = 1'b1;

  logic        ir_a, ir_s, ir_w;
  logic        ov_a, ov_s, ov_w;
  logic        of_a, of_s, of_w;
  logic [15:0] od_a;
  logic [11:0] od_s, od_w;
  logic        i_data_ready;

  assign i_data_ready = ir_a;

  svnet_tree_accum #(.WIDTH(8), .COUNT(9), .REG_EVERY(1), .ACC_WIDTH(16), .SATURATE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .i_data_valid(i_data_valid), .i_data_ready(ir_a),
    .i_data_last(i_data_last), .i_data(i_data), .o_data_valid(ov_a), .o_data_ready(o_data_ready),
    .o_data(od_a), .o_data_overflow(of_a));
  svnet_tree_accum #(.WIDTH(8), .COUNT(9), .REG_EVERY(1), .ACC_WIDTH(12), .SATURATE(1)) u_s (
    .clk(clk), .rst_n(rst_n), .i_data_valid(i_data_valid), .i_data_ready(ir_s),
    .i_data_last(i_data_last), .i_data(i_data), .o_data_valid(ov_s), .o_data_ready(o_data_ready),
    .o_data(od_s), .o_data_overflow(of_s));
  svnet_tree_accum #(.WIDTH(8), .COUNT(9), .REG_EVERY(1), .ACC_WIDTH(12), .SATURATE(0)) u_w (
    .clk(clk), .rst_n(rst_n), .i_data_valid(i_data_valid), .i_data_ready(ir_w),
    .i_data_last(i_data_last), .i_data(i_data), .o_data_valid(ov_w), .o_data_ready(o_data_ready),
    .o_data(od_w), .o_data_overflow(of_w));

  always #5 clk = ~clk;

  typedef struct { longint v0, v1, v2; bit f0, f1, f2; int cyc; } exp_t;

  int     nvec = 0;
  int     nmis = 0;
  int     cyc  = 0;
  int     n_res = 0;
  int     rdy_mode = 0;
  exp_t   exp_q[$];
  longint acc_m [3];
  bit     ovf_m [3];
  longint last_v0, last_v1, last_v2;
  bit     last_f0, last_f1, last_f2;
  int     last_lat;
  bit     prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic clear_acc();
    for (int k = 0; k < 3; k++) begin
      acc_m[k] = 0;
      ovf_m[k] = 1'b0;
    end
  endtask

  // Running packet sum per configuration: range-check every step, then clamp or wrap.
  task automatic model_beat(input longint s, input bit last, input int c);
    longint hi, lo, m, nx;
    exp_t   e;
    for (int k = 0; k < 3; k++) begin
      hi = (k == 0) ? 32767 : 2047;
      lo = -hi - 1;
      m  = 2 * (hi + 1);
      nx = acc_m[k] + s;
      if (nx > hi || nx < lo) begin
        ovf_m[k] = 1'b1;
        if (k == 1) nx = (nx > hi) ? hi : lo;
        else begin
          nx = nx % m;
          if (nx < 0) nx += m;
          if (nx > hi) nx -= m;
        end
      end
      acc_m[k] = nx;
    end
    if (last) begin
      e.v0 = acc_m[0]; e.v1 = acc_m[1]; e.v2 = acc_m[2];
      e.f0 = ovf_m[0]; e.f1 = ovf_m[1]; e.f2 = ovf_m[2];
      e.cyc = c;
      exp_q.push_back(e);
      clear_acc();
    end
  endtask

  always @(negedge clk) begin
    exp_t          e;
    longint        bs;
    logic signed [7:0] b;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", ir_a, (!ov_a || o_data_ready) ? 1 : 0);
      chk("lockstep", {ov_s, ov_w, ir_s, ir_w}, {ov_a, ov_a, ir_a, ir_a});
      if (prev_stall) chk("stall_hold", {ov_a, od_a}, {1'b1, prev_data});
      if (ov_a && o_data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_w16", {of_a, 64'($signed(od_a))}, {e.f0, 64'(e.v0)});
          chk("res_s12", {of_s, 64'($signed(od_s))}, {e.f1, 64'(e.v1)});
          chk("res_w12", {of_w, 64'($signed(od_w))}, {e.f2, 64'(e.v2)});
          last_v0 = e.v0; last_v1 = e.v1; last_v2 = e.v2;
          last_f0 = e.f0; last_f1 = e.f1; last_f2 = e.f2;
          last_lat = cyc - e.cyc;
          n_res++;
        end
      end
      prev_stall = ov_a && !o_data_ready;
      prev_data  = od_a;
      if (i_data_valid && ir_a) begin
        bs = 0;
        for (int j = 0; j < 9; j++) begin
          b  = i_data[j*8 +: 8];
          bs += longint'(b);
        end
        model_beat(bs, i_data_last, cyc);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: o_data_ready = 1'b1;
      1: o_data_ready = 1'b0;
      default: o_data_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  function automatic logic [71:0] fill(input logic [7:0] v);
    logic [71:0] d;
    for (int j = 0; j < 9; j++) d[j*8 +: 8] = v;
    return d;
  endfunction

  function automatic logic [71:0] rand_beat();
    logic [71:0] d;
    int          mode;
    mode = $urandom_range(0, 3);
    d = '0;
    for (int j = 0; j < 9; j++) begin
      case (mode)
        0: d[j*8 +: 8] = 8'($urandom);
        1: d[j*8 +: 8] = 8'h7f;
        2: d[j*8 +: 8] = 8'h80;
        default: d[j*8 +: 8] = 8'($urandom_range(0, 7) - 4);
      endcase
    end
    return d;
  endfunction

  // Called in the posedge+1 phase; returns in the same phase after the beat is taken.
  task automatic send_beat(input logic [71:0] d, input bit last);
    bit ok;
    ok = 1'b0;
    i_data = d;
    i_data_last = last;
    i_data_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (i_data_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    i_data_last  = 1'($urandom);
    i_data       = {8'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ov_a) begin seen = 1'b1; break; end
    end
    chk("wait_valid_timeout", seen, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n0;
    int  nb;
    bit  ok;
    clear_acc();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", ov_a, 0);
    chk("reset_data", od_a, 0);
    chk("reset_ovf", of_a, 0);
    chk("reset_in_ready", ir_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 9 x 127 in one beat: 1143, five cycles from accept to valid
    send_beat(fill(8'h7f), 1'b1);
    drain(50);
    chk("t1_sum", last_v0, 1143);
    chk("t1_ovf", last_f0, 0);
    chk("t1_latency", last_lat, 5);

    send_beat(fill(8'h80), 1'b1);
    drain(50);
    chk("t2_sum", last_v0, -1152);
    chk("t2_ovf", last_f0, 0);

    n0 = n_res;
    for (int b = 0; b < 3; b++) send_beat(fill(8'd1), b == 2);
    drain(50);
    chk("t3_count", n_res - n0, 1);
    chk("t3_sum", last_v0, 27);
    send_beat(fill(8'd2), 1'b1);
    drain(50);
    chk("t3_next", last_v0, 18);

    // Output stalled with beats waiting upstream
    rdy_mode = 1;
    n0 = n_res;
    send_beat(fill(8'd3), 1'b1);
    send_beat(fill(8'd4), 1'b0);
    send_beat(fill(8'd5), 1'b1);
    wait_valid(20);
    i_data = fill(8'd6);
    i_data_last = 1'b1;
    i_data_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t4_in_ready", i_data_ready, 0);
      chk("t4_hold", longint'($signed(od_a)), 27);
    end
    rdy_mode = 0;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (i_data_ready) begin ok = 1'b1; break; end
    end
    chk("t4_release", ok, 1);
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    drain(50);
    chk("t4_count", n_res - n0, 3);
    chk("t4_last", last_v0, 54);

    for (int b = 0; b < 3; b++) send_beat(fill(8'h7f), b == 2);
    drain(50);
    chk("t5_sat", {last_f1, 64'(last_v1)}, {1'b1, 64'(2047)});
    chk("t5_wrap", {last_f2, 64'(last_v2)}, {1'b1, 64'(-667)});
    chk("t5_wide", {last_f0, 64'(last_v0)}, {1'b0, 64'(3429)});
    send_beat(fill(8'd0), 1'b1);
    drain(50);
    chk("t5_clear", {last_f1, last_f2, 64'(last_v1)}, {2'b00, 64'(0)});

    // Reset with a result pending and a packet half-accumulated
    rdy_mode = 1;
    send_beat(fill(8'd1), 1'b1);
    send_beat(fill(8'd1), 1'b0);
    send_beat(fill(8'd1), 1'b0);
    wait_valid(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", ov_a, 0);
    chk("t6_async_data", od_a, 0);
    chk("t6_async_ovf", of_a, 0);
    exp_q.delete();
    clear_acc();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_res;
    send_beat(fill(8'd1), 1'b1);
    drain(50);
    chk("t6_after", last_v0, 9);
    chk("t6_count", n_res - n0, 1);

    rdy_mode = 2;
    for (int p = 0; p < 150; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        send_beat(rand_beat(), b == nb - 1);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    rdy_mode = 0;
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
